// File: rtl/fp_div_pkg.sv
// IEEE-754 single-precision field layout and exception classification
// shared by the divider issue stage.
package fp_div_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;

  localparam logic [7:0]  EXP_ALL1  = 8'hFF;
  localparam logic [31:0] POS_INF   = 32'h7F800000;
  localparam logic [31:0] SIGN_MASK = 32'h1 << SIGN_BIT;

  // Exception flags in output bit order: {NV, DZ}.
  typedef struct packed {
    logic nv;
    logic dz;
  } fp_flags_t;

  // Magnitude with the sign bit cleared.
  // Comparing magnitudes against +inf avoids separate exponent/mantissa tests.
  function automatic logic [31:0] fp_mag(input logic [31:0] x);
    return x & ~SIGN_MASK;
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return fp_mag(x) > POS_INF;
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return fp_mag(x) == POS_INF;
  endfunction

  // Denormals are nonzero; only +0 and -0 count as zero.
  function automatic logic is_zero(input logic [31:0] x);
    return fp_mag(x) == '0;
  endfunction

  // Invalid: any NaN, 0/0 or inf/inf. Divide-by-zero: finite nonzero / 0.
  // The two cases are disjoint by construction.
  function automatic fp_flags_t classify(input logic [31:0] a, input logic [31:0] b);
    fp_flags_t f;
    f.nv = is_nan(a) || is_nan(b) || (is_zero(a) && is_zero(b)) ||
           (is_inf(a) && is_inf(b));
    f.dz = is_zero(b) && !is_zero(a) && !is_inf(a) && !is_nan(a);
    return f;
  endfunction

endpackage

// File: rtl/fp_div_op_fifo.sv
// Operand-pair FIFO. The head entry reads as zero when the FIFO is empty so
// the downstream combinational divider sees a quiet input. Pushes at full
// and pops at empty are ignored.
module fp_div_op_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNTW-1:0]  count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNTW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry storage; no reset needed since empty entries are never observed.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fp_div_issue_stage.sv
// Flow-controlled issue stage around an external combinational FP divider:
// queues operand pairs, presents the head pair to the divider and registers
// the quotient plus {NV, DZ} behind a valid/ready output handshake.
module fp_div_issue_stage
  import fp_div_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 4,
  parameter int CNTW      = $clog2(DEPTH) + 1
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_A,
  input  logic [DATAWIDTH-1:0] in_B,
  output logic [DATAWIDTH-1:0] div_A,
  output logic [DATAWIDTH-1:0] div_B,
  input  logic [DATAWIDTH-1:0] div_Y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_Y,
  output logic [1:0]           out_flags,
  output logic [CNTW-1:0]      occupancy
);

  logic [2*DATAWIDTH-1:0] head;
  logic                   fifo_full, fifo_empty, pop;

  logic                   out_valid_q, out_valid_d;
  logic [DATAWIDTH-1:0]   out_y_q, out_y_d;
  fp_flags_t              flags_q, flags_d;

  fp_div_op_fifo #(
    .WIDTH (2*DATAWIDTH),
    .DEPTH (DEPTH),
    .CNTW  (CNTW)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (Rst_n),
    .push_i  (in_valid),
    .wdata_i ({in_A, in_B}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (occupancy)
  );

  // No bypass at full: a pop frees the slot only on the following cycle.
  assign in_ready = !fifo_full;
  assign div_A    = head[2*DATAWIDTH-1:DATAWIDTH];
  assign div_B    = head[DATAWIDTH-1:0];

  // Head moves into the output register whenever that register is free or
  // being drained this cycle.
  assign pop = !fifo_empty && (!out_valid_q || out_ready);

  // Output register next state: capture, drain, or hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    flags_d     = flags_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_y_d     = div_Y;
      flags_d     = classify(div_A, div_B);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register; reset discards any held result.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_Y     = out_y_q;
  assign out_flags = flags_q;

endmodule

// File: tb/tb_fp_div_issue_stage.sv
module tb_fp_div_issue_stage;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CNTW  = 3;

  logic            Clk = 1'b0;
  logic            Rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_A, in_B;
  logic [DW-1:0]   div_A, div_B, div_Y;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_Y;
  logic [1:0]      out_flags;
  logic [CNTW-1:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queued pairs plus the visible output register.
  logic [63:0] mq[$];
  bit          mv;
  logic [31:0] my;
  logic [1:0]  mf;

  always #5 Clk = ~Clk;

  // Stand-in for the external divider: exact for 6/2, inf for x/0, else a hash.
  function automatic logic [31:0] fake_div(input logic [31:0] a, input logic [31:0] b);
    int unsigned ea = (a >> 23) & 32'hFF;
    if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    if ((b & 32'h7FFFFFFF) == 0 && (a & 32'h7FFFFFFF) != 0 && ea != 255)
      return {a[31] ^ b[31], 31'h7F800000};
    return (a ^ {b[15:0], b[31:16]}) + 32'h01234567;
  endfunction

  function automatic logic [1:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
    int unsigned ea = (a >> 23) & 32'hFF;
    int unsigned ma = a & 32'h7FFFFF;
    int unsigned eb = (b >> 23) & 32'hFF;
    int unsigned mb = b & 32'h7FFFFF;
    bit a_nan  = (ea == 255) && (ma != 0);
    bit b_nan  = (eb == 255) && (mb != 0);
    bit a_inf  = (ea == 255) && (ma == 0);
    bit b_inf  = (eb == 255) && (mb == 0);
    bit a_zero = (ea == 0) && (ma == 0);
    bit b_zero = (eb == 0) && (mb == 0);
    bit nv = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
    bit dz = b_zero && !a_zero && (ea != 255);
    return {nv, dz};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] sp[8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                           32'h7FC00000, 32'hFF812345, 32'h00000001, 32'h3F800000};
    if ($urandom_range(0, 2) == 0) return sp[$urandom_range(0, 7)];
    return $urandom();
  endfunction

  assign div_Y = fake_div(div_A, div_B);

  fp_div_issue_stage #(.DATAWIDTH(DW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_A      (in_A),
    .in_B      (in_B),
    .div_A     (div_A),
    .div_B     (div_B),
    .div_Y     (div_Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_Y     (out_Y),
    .out_flags (out_flags),
    .occupancy (occupancy)
  );

  task automatic model_clear();
    mq.delete();
    mv = 0;
    my = '0;
    mf = '0;
  endtask

  // Drive one cycle from a negedge and advance the model across the posedge.
  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b,
                      input bit rdy, output bit acc, output bit popped);
    logic [63:0] h;
    in_valid  = v;
    in_A      = a;
    in_B      = b;
    out_ready = rdy;
    acc    = v && (mq.size() < DEPTH);
    popped = (mq.size() != 0) && (!mv || rdy);
    if (popped) begin
      h  = mq.pop_front();
      my = fake_div(h[63:32], h[31:0]);
      mf = ref_flags(h[63:32], h[31:0]);
      mv = 1;
    end else if (rdy) begin
      mv = 0;
    end
    if (acc) mq.push_back({a, b});
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    n_checks++;
    if ({out_valid, out_Y, out_flags} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_out: got valid=%b Y=%h flags=%b expected 0/0/0", out_valid, out_Y, out_flags);
    end
    n_checks++;
    if (occupancy !== 3'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_fifo: got occ=%0d in_ready=%b expected 0/1", occupancy, in_ready);
    end
    n_checks++;
    if ({div_A, div_B} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_div_ops: got %h/%h expected 0/0", div_A, div_B);
    end
  endtask

  task automatic test_basic();
    bit acc, pp;
    step(1, 32'h40C00000, 32'h40000000, 1, acc, pp);
    n_checks++;
    if (occupancy !== 3'd1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_queued: got occ=%0d valid=%b expected 1/0", occupancy, out_valid);
    end
    n_checks++;
    if (div_A !== 32'h40C00000 || div_B !== 32'h40000000) begin
      n_fail++;
      $display("FAIL basic_head: got %h/%h expected 40c00000/40000000", div_A, div_B);
    end
    step(0, 0, 0, 1, acc, pp);
    n_checks++;
    if (out_valid !== 1'b1 || out_Y !== 32'h40400000 || out_flags !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_result: got valid=%b Y=%h flags=%b expected 1/40400000/00", out_valid, out_Y, out_flags);
    end
    step(0, 0, 0, 1, acc, pp);
    n_checks++;
    if (out_valid !== 1'b0 || out_Y !== 32'h40400000) begin
      n_fail++;
      $display("FAIL basic_drain: got valid=%b Y=%h expected 0/40400000", out_valid, out_Y);
    end
  endtask

  task automatic test_flags();
    logic [31:0] ta[4] = '{32'h3F800000, 32'h00000000, 32'h7FC00000, 32'h7F800000};
    logic [31:0] tb[4] = '{32'h00000000, 32'h00000000, 32'h3F800000, 32'hFF800000};
    logic [1:0]  tf[4] = '{2'b01, 2'b10, 2'b10, 2'b10};
    bit acc, pp;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) step(1, ta[i], tb[i], 1, acc, pp);
      else       step(0, 0, 0, 1, acc, pp);
      if (i >= 1) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_flags !== tf[i-1]) begin
          n_fail++;
          $display("FAIL flags_%0d: got valid=%b flags=%b expected 1/%b", i-1, out_valid, out_flags, tf[i-1]);
        end
      end
      if (i == 1) begin
        n_checks++;
        if (out_Y !== 32'h7F800000) begin
          n_fail++;
          $display("FAIL flags_dz_quot: got %h expected 7f800000", out_Y);
        end
      end
    end
    step(0, 0, 0, 1, acc, pp);
  endtask

  task automatic test_backpressure();
    logic [31:0] pa[5], pb[5];
    logic [31:0] y0;
    int idx = 0;
    int npop = 0;
    bit acc, pp;
    for (int i = 0; i < 5; i++) begin
      pa[i] = rand_op();
      pb[i] = rand_op();
    end
    step(1, 32'h40C00000, 32'h40000000, 0, acc, pp);
    step(0, 0, 0, 0, acc, pp);
    y0 = fake_div(32'h40C00000, 32'h40000000);
    for (int c = 0; c < 6; c++) begin
      step(1, pa[idx], pb[idx], 0, acc, pp);
      if (acc) idx++;
      n_checks++;
      if (out_valid !== 1'b1 || out_Y !== y0) begin
        n_fail++;
        $display("FAIL bp_hold cyc %0d: got valid=%b Y=%h expected 1/%h", c, out_valid, out_Y, y0);
      end
    end
    n_checks++;
    if (idx != 4 || occupancy !== 3'd4 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: got accepted=%0d occ=%0d in_ready=%b expected 4/4/0", idx, occupancy, in_ready);
    end
    for (int c = 0; c < 20 && (idx < 5 || mq.size() != 0 || mv); c++) begin
      if (idx < 5) step(1, pa[idx], pb[idx], 1, acc, pp);
      else         step(0, 0, 0, 1, acc, pp);
      if (acc) idx++;
      if (pp) npop++;
      n_checks++;
      if (out_valid !== mv || out_Y !== my || out_flags !== mf || occupancy !== CNTW'(mq.size())) begin
        n_fail++;
        $display("FAIL bp_drain cyc %0d: got valid=%b Y=%h flags=%b occ=%0d expected %b/%h/%b/%0d",
                 c, out_valid, out_Y, out_flags, occupancy, mv, my, mf, mq.size());
      end
    end
    n_checks++;
    if (idx != 5 || npop != 5 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_count: got accepted=%0d results=%0d valid=%b expected 5/5/0", idx, npop, out_valid);
    end
  endtask

  task automatic test_streaming();
    int npop = 0;
    bit acc, pp;
    for (int c = 0; c < 18; c++) begin
      if (c < 16) step(1, rand_op(), rand_op(), 1, acc, pp);
      else        step(0, 0, 0, 1, acc, pp);
      if (pp) npop++;
      n_checks++;
      if (out_valid !== mv || out_Y !== my || out_flags !== mf || occupancy > 3'd1) begin
        n_fail++;
        $display("FAIL stream cyc %0d: got valid=%b Y=%h flags=%b occ=%0d expected %b/%h/%b/<=1",
                 c, out_valid, out_Y, out_flags, occupancy, mv, my, mf);
      end
      if (c >= 1 && c <= 16) begin
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_rate cyc %0d: got valid=%b expected 1", c, out_valid);
        end
      end
    end
    n_checks++;
    if (npop != 16) begin
      n_fail++;
      $display("FAIL stream_count: got %0d expected 16", npop);
    end
  endtask

  task automatic test_random();
    bit acc, pp;
    for (int c = 0; c < 300; c++) begin
      step($urandom_range(0, 3) != 0, rand_op(), rand_op(), $urandom_range(0, 2) != 0, acc, pp);
      n_checks++;
      if (out_valid !== mv || out_Y !== my || out_flags !== mf) begin
        n_fail++;
        $display("FAIL rand_out cyc %0d: got valid=%b Y=%h flags=%b expected %b/%h/%b",
                 c, out_valid, out_Y, out_flags, mv, my, mf);
      end
      n_checks++;
      if (occupancy !== CNTW'(mq.size()) || in_ready !== (mq.size() < DEPTH)) begin
        n_fail++;
        $display("FAIL rand_fifo cyc %0d: got occ=%0d in_ready=%b expected %0d/%b",
                 c, occupancy, in_ready, mq.size(), (mq.size() < DEPTH));
      end
    end
    for (int c = 0; c < 8; c++) step(0, 0, 0, 1, acc, pp);
  endtask

  task automatic test_reset_midstream();
    bit acc, pp;
    for (int c = 0; c < 4; c++) step(1, rand_op(), rand_op(), 0, acc, pp);
    n_checks++;
    if (occupancy !== 3'd3 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup: got occ=%0d valid=%b expected 3/1", occupancy, out_valid);
    end
    in_valid = 0;
    #2 Rst_n = 0;
    #1;
    model_clear();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0 || out_Y !== 32'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%b occ=%0d Y=%h in_ready=%b expected 0/0/0/1",
               out_valid, occupancy, out_Y, in_ready);
    end
    @(negedge Clk);
    Rst_n = 1;
    step(1, 32'h40C00000, 32'h40000000, 1, acc, pp);
    step(0, 0, 0, 1, acc, pp);
    n_checks++;
    if (out_valid !== 1'b1 || out_Y !== 32'h40400000 || out_flags !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_after: got valid=%b Y=%h flags=%b expected 1/40400000/00", out_valid, out_Y, out_flags);
    end
  endtask

  initial begin
    Rst_n     = 0;
    in_valid  = 0;
    in_A      = '0;
    in_B      = '0;
    out_ready = 0;
    model_clear();
    repeat (3) @(negedge Clk);
    test_reset();
    Rst_n = 1;
    @(negedge Clk);
    test_reset();
    test_basic();
    test_flags();
    test_backpressure();
    test_streaming();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
